// File: rtl/beamformer_sequencer.sv
// Frame sequencer for the beamformer datapath: filter stream, capture, slice replay, drain, readout.
// Optional macro SEQ_READOUT_EN adds the READOUT state; without it DRAIN goes straight to DONE.
module beamformer_sequencer #(
    parameter int NUM_SAMPLES  = 2048,
    parameter int FLUSH_CYCLES = 64,
    parameter int NUM_OUT      = 1024,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        valid_out,
    input  logic        rd_ready,
    output logic        start,
    output logic        signalinen,
    output logic [10:0] signal_address,
    output logic        filter_bram_output_write_en,
    output logic [10:0] readin_address,
    output logic        output_read_en,
    output logic        startbeamformer,
    output logic [1:0]  slice_state,
    output logic [15:0] sample_index,
    output logic        sumouten,
    output logic [9:0]  sumout_address,
    output logic        out_valid,
    output logic        busy,
    output logic        done
);

    localparam int SW = $clog2(NUM_SAMPLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int TW = (FW > DW) ? FW : DW;

    localparam logic [SW-1:0] SIG_LAST   = SW'(NUM_SAMPLES - 1);
    localparam logic [SW-1:0] N_SAMP     = SW'(NUM_SAMPLES);
    localparam logic [TW-1:0] FLUSH_LAST = TW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILTER, S_FLUSH, S_BEAM, S_DRAIN, S_READOUT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  addr_q, addr_d;
    logic [SW-1:0]  wcnt_q, wcnt_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [1:0]     slice_q, slice_d;
    logic [15:0]    sidx_q, sidx_d;
    logic           start_q;

`ifdef SEQ_READOUT_EN
    localparam int RW = $clog2(NUM_OUT + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(NUM_OUT - 1);
    logic [RW-1:0]  rd_addr_q, rd_addr_d;
    logic           out_valid_q;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        tmr_d   = tmr_q;
        slice_d = slice_q;
        sidx_d  = sidx_q;
        signalinen                  = 1'b0;
        signal_address              = '0;
        filter_bram_output_write_en = 1'b0;
        readin_address              = '0;
        output_read_en              = 1'b0;
        startbeamformer             = 1'b0;
        slice_state                 = '0;
        sample_index                = '0;
        busy                        = (state_q != S_IDLE);
        done                        = 1'b0;

        // Capture runs through FILTER and FLUSH; words past NUM_SAMPLES are dropped.
        if (state_q == S_FILTER || state_q == S_FLUSH) begin
            readin_address = 11'(wcnt_q);
            if (valid_out && wcnt_q != N_SAMP) begin
                filter_bram_output_write_en = 1'b1;
                wcnt_d = wcnt_q + SW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_FILTER;
                    addr_d  = '0;
                    wcnt_d  = '0;
                    tmr_d   = '0;
                    slice_d = '0;
                    sidx_d  = '0;
                end
            end
            S_FILTER: begin
                signalinen     = 1'b1;
                signal_address = 11'(addr_q);
                addr_d         = addr_q + SW'(1);
                if (addr_q == SIG_LAST) begin
                    state_d = S_FLUSH;
                    addr_d  = '0;
                    tmr_d   = '0;
                end
            end
            S_FLUSH: begin
                tmr_d = tmr_q + TW'(1);
                if (wcnt_d == N_SAMP || tmr_q == FLUSH_LAST) begin
                    tmr_d   = '0;
                    state_d = (wcnt_d == '0) ? S_DRAIN : S_BEAM;
                end
            end
            S_BEAM: begin
                startbeamformer = 1'b1;
                slice_state     = slice_q;
                sample_index    = sidx_q;
                slice_d         = slice_q + 2'd1;
                if (slice_q == 2'd0) begin
                    output_read_en = 1'b1;
                    readin_address = 11'(addr_q);
                end else if (slice_q == 2'd3) begin
                    addr_d = addr_q + SW'(1);
                    if (addr_q + SW'(1) == wcnt_q) begin
                        state_d = S_DRAIN;
                        addr_d  = '0;
                    end
                end
                // Index is held on the final slice so it reads 3*count-1 at frame end.
                if (slice_q != 2'd0 && state_d == S_BEAM)
                    sidx_d = sidx_q + 16'd1;
            end
            S_DRAIN: begin
                startbeamformer = 1'b1;
                sample_index    = sidx_q;
                tmr_d           = tmr_q + TW'(1);
                if (tmr_q == DRAIN_LAST) begin
                    tmr_d = '0;
`ifdef SEQ_READOUT_EN
                    state_d = S_READOUT;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_READOUT: begin
`ifdef SEQ_READOUT_EN
                if (rd_ready && rd_addr_q == RD_LAST)
                    state_d = S_DONE;
`else
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            tmr_q   <= '0;
            slice_q <= '0;
            sidx_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            tmr_q   <= tmr_d;
            slice_q <= slice_d;
            sidx_q  <= sidx_d;
            start_q <= signalinen;
        end
    end

    // Signal RAM has one cycle of read latency, so filter valid trails the read enable.
    assign start = start_q;

`ifdef SEQ_READOUT_EN
    always_comb begin
        rd_addr_d = rd_addr_q;
        sumouten  = 1'b0;
        if (state_q == S_READOUT) begin
            sumouten = rd_ready;
            if (rd_ready)
                rd_addr_d = rd_addr_q + RW'(1);
        end else if (state_q == S_IDLE) begin
            rd_addr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= sumouten;
        end
    end

    assign sumout_address = (state_q == S_READOUT) ? 10'(rd_addr_q) : '0;
    assign out_valid      = out_valid_q;
`else
    logic unused_rd_ready;
    assign unused_rd_ready = rd_ready;
    assign sumouten        = 1'b0;
    assign sumout_address  = '0;
    assign out_valid       = 1'b0;
`endif

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Directed bench for beamformer_sequencer with small frame parameters and a 3-cycle filter model.
module tb_beamformer_sequencer;
    localparam int NS = 8;
    localparam int FC = 64;
    localparam int NO = 4;
    localparam int DC = 8;
`ifdef SEQ_READOUT_EN
    localparam int RD_EXTRA = NO;
`else
    localparam int RD_EXTRA = 0;
`endif
    // go at cycle 0: FILTER 1..8, writes 5..12, BEAM 13..44, DRAIN 45..52, then readout/DONE
    localparam int EXP_DONE_FULL = 53 + RD_EXTRA;
    // no captures: FLUSH 9..72, DRAIN 73..80, then readout/DONE
    localparam int EXP_DONE_TMO  = 81 + RD_EXTRA;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        valid_out = 1'b0;
    logic        rd_ready = 1'b0;
    logic        start, signalinen, filter_bram_output_write_en, output_read_en;
    logic        startbeamformer, sumouten, out_valid, busy, done;
    logic [10:0] signal_address, readin_address;
    logic [1:0]  slice_state;
    logic [15:0] sample_index;
    logic [9:0]  sumout_address;

    bit          filt_en = 1'b0;
    bit          rd_toggle = 1'b0;
    logic [2:0]  vhist = 3'b000;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        int n_wr; int wr_bad; int first_sbf; int beam_cyc; int beam_bad;
        int last_sidx; int last_s3; int done_cyc; int done_cnt;
        int se_cnt; int rd_bad; int ov_cnt; int ov_bad;
    } res_t;

    beamformer_sequencer #(
        .NUM_SAMPLES(NS), .FLUSH_CYCLES(FC), .NUM_OUT(NO), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .valid_out(valid_out), .rd_ready(rd_ready),
        .start(start), .signalinen(signalinen), .signal_address(signal_address),
        .filter_bram_output_write_en(filter_bram_output_write_en),
        .readin_address(readin_address), .output_read_en(output_read_en),
        .startbeamformer(startbeamformer), .slice_state(slice_state),
        .sample_index(sample_index), .sumouten(sumouten), .sumout_address(sumout_address),
        .out_valid(out_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Advance one cycle; inputs for the new cycle are applied, then outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
        valid_out = filt_en & vhist[2];
        vhist     = {vhist[1:0], start};
        rd_ready  = rd_toggle ? ~rd_ready : 1'b1;
        #1;
    endtask

    // Runs one frame from IDLE and gathers observations; go is re-pulsed at go_again if nonzero.
    task automatic run_frame(input bit filt, input bit tog, input int go_again, output res_t r);
        logic prev_se;
        int a, s, e;
        r = '{default: 0};
        r.first_sbf = -1; r.last_s3 = -1; r.done_cyc = -1; r.last_sidx = -1;
        filt_en = filt; rd_toggle = tog; vhist = 3'b000; valid_out = 1'b0; rd_ready = 1'b1;
        prev_se = 1'b0;
        go = 1'b1;
        step();
        for (int cyc = 1; cyc < 400; cyc++) begin
            go = (go_again > 0 && cyc >= go_again && cyc < go_again + 3);
            if (filter_bram_output_write_en) begin
                if (readin_address != 11'(r.n_wr)) r.wr_bad++;
                r.n_wr++;
            end
            if (startbeamformer && r.first_sbf < 0) r.first_sbf = cyc;
            if (output_read_en || slice_state != 2'd0) begin
                a = r.beam_cyc / 4;
                s = r.beam_cyc % 4;
                e = 3 * a + ((s == 0) ? 0 : s - 1);
                if (slice_state != 2'(s) || sample_index != 16'(e)) r.beam_bad++;
                if (s == 0 && (!output_read_en || readin_address != 11'(a))) r.beam_bad++;
                if (s != 0 && output_read_en) r.beam_bad++;
                if (s == 3) r.last_s3 = cyc;
                r.last_sidx = int'(sample_index);
                r.beam_cyc++;
            end
            if (sumouten) begin
                if (sumout_address != 10'(r.se_cnt) || !rd_ready) r.rd_bad++;
                r.se_cnt++;
            end
            if (out_valid !== prev_se) r.ov_bad++;
            if (out_valid) r.ov_cnt++;
            prev_se = sumouten;
            if (done) begin
                r.done_cnt++;
                if (r.done_cyc < 0) r.done_cyc = cyc;
            end
            if (!busy && r.done_cyc >= 0) break;
            step();
        end
        go = 1'b0; filt_en = 1'b0; valid_out = 1'b0; rd_toggle = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; go = 1'b0; valid_out = 1'b0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (signalinen !== 1'b0 || start !== 1'b0) begin failures++; $display("FAIL reset_filter_en got=%0b%0b exp=00", signalinen, start); end
        checks++; if (signal_address !== 11'd0) begin failures++; $display("FAIL reset_sig_addr got=%0d exp=0", signal_address); end
        checks++; if (startbeamformer !== 1'b0 || slice_state !== 2'd0) begin failures++; $display("FAIL reset_beam got=%0b/%0d exp=0/0", startbeamformer, slice_state); end
        checks++; if (sumouten !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_rd_done got=%0b%0b%0b exp=000", sumouten, out_valid, done); end
        rst = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0 || signalinen !== 1'b0) begin failures++; $display("FAIL idle_hold got=%0b%0b exp=00", busy, signalinen); end
    endtask

    task automatic test_start_timing();
        go = 1'b1;
        step();
        go = 1'b0;
        checks++; if (signalinen !== 1'b1 || start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL cyc1_en got=%0b%0b%0b exp=101", signalinen, start, busy); end
        checks++; if (signal_address !== 11'd0) begin failures++; $display("FAIL cyc1_addr got=%0d exp=0", signal_address); end
        step();
        checks++; if (start !== 1'b1 || signal_address !== 11'd1) begin failures++; $display("FAIL cyc2 got=%0b/%0d exp=1/1", start, signal_address); end
        for (int i = 0; i < 300 && busy; i++) step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_frame_end got=%0b exp=0", busy); end
    endtask

    task automatic test_full_frame();
        res_t r;
        run_frame(1'b1, 1'b0, 0, r);
        checks++; if (r.n_wr != NS) begin failures++; $display("FAIL full_writes got=%0d exp=%0d", r.n_wr, NS); end
        checks++; if (r.wr_bad != 0) begin failures++; $display("FAIL full_wr_addr got=%0d exp=0", r.wr_bad); end
        checks++; if (r.first_sbf != 13) begin failures++; $display("FAIL full_flush_exit got=%0d exp=13", r.first_sbf); end
        checks++; if (r.beam_cyc != 4 * NS) begin failures++; $display("FAIL full_beam_len got=%0d exp=%0d", r.beam_cyc, 4 * NS); end
        checks++; if (r.beam_bad != 0) begin failures++; $display("FAIL full_beam_seq got=%0d exp=0", r.beam_bad); end
        checks++; if (r.last_sidx != 23) begin failures++; $display("FAIL full_last_sidx got=%0d exp=23", r.last_sidx); end
        checks++; if (r.last_s3 != 44) begin failures++; $display("FAIL full_last_slice got=%0d exp=44", r.last_s3); end
        checks++; if (r.done_cyc != EXP_DONE_FULL) begin failures++; $display("FAIL full_done_cyc got=%0d exp=%0d", r.done_cyc, EXP_DONE_FULL); end
        checks++; if (r.done_cnt != 1) begin failures++; $display("FAIL full_done_cnt got=%0d exp=1", r.done_cnt); end
        checks++; if (r.se_cnt != RD_EXTRA || r.ov_cnt != RD_EXTRA) begin failures++; $display("FAIL full_readout got=%0d/%0d exp=%0d", r.se_cnt, r.ov_cnt, RD_EXTRA); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_idle got=%0b%0b exp=00", done, busy); end
    endtask

    task automatic test_flush_timeout();
        res_t r;
        run_frame(1'b0, 1'b0, 0, r);
        checks++; if (r.n_wr != 0) begin failures++; $display("FAIL tmo_writes got=%0d exp=0", r.n_wr); end
        checks++; if (r.first_sbf != 9 + FC) begin failures++; $display("FAIL tmo_flush_len got=%0d exp=%0d", r.first_sbf, 9 + FC); end
        checks++; if (r.beam_cyc != 0) begin failures++; $display("FAIL tmo_beam_len got=%0d exp=0", r.beam_cyc); end
        checks++; if (r.done_cyc != EXP_DONE_TMO || r.done_cnt != 1) begin failures++; $display("FAIL tmo_done got=%0d/%0d exp=%0d/1", r.done_cyc, r.done_cnt, EXP_DONE_TMO); end
    endtask

`ifdef SEQ_READOUT_EN
    task automatic test_readout_toggle();
        res_t r;
        run_frame(1'b0, 1'b1, 0, r);
        checks++; if (r.se_cnt != NO) begin failures++; $display("FAIL rd_reads got=%0d exp=%0d", r.se_cnt, NO); end
        checks++; if (r.rd_bad != 0) begin failures++; $display("FAIL rd_addr_seq got=%0d exp=0", r.rd_bad); end
        checks++; if (r.ov_cnt != NO) begin failures++; $display("FAIL rd_out_valid_cnt got=%0d exp=%0d", r.ov_cnt, NO); end
        checks++; if (r.ov_bad != 0) begin failures++; $display("FAIL rd_out_valid_lag got=%0d exp=0", r.ov_bad); end
        checks++; if (r.done_cnt != 1) begin failures++; $display("FAIL rd_done_cnt got=%0d exp=1", r.done_cnt); end
    endtask
`else
    task automatic test_no_readout();
        res_t r;
        run_frame(1'b1, 1'b1, 0, r);
        checks++; if (r.done_cyc - r.last_s3 != DC + 1) begin failures++; $display("FAIL nord_done_gap got=%0d exp=%0d", r.done_cyc - r.last_s3, DC + 1); end
        checks++; if (r.se_cnt != 0 || r.ov_cnt != 0) begin failures++; $display("FAIL nord_sumouten got=%0d/%0d exp=0/0", r.se_cnt, r.ov_cnt); end
    endtask
`endif

    task automatic test_go_ignored();
        res_t r;
        run_frame(1'b1, 1'b0, 20, r);
        checks++; if (r.done_cyc != EXP_DONE_FULL || r.done_cnt != 1) begin failures++; $display("FAIL go_done got=%0d/%0d exp=%0d/1", r.done_cyc, r.done_cnt, EXP_DONE_FULL); end
        checks++; if (r.beam_cyc != 4 * NS || r.beam_bad != 0 || r.n_wr != NS) begin failures++; $display("FAIL go_frame got=%0d/%0d/%0d exp=%0d/0/%0d", r.beam_cyc, r.beam_bad, r.n_wr, 4 * NS, NS); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL go_no_restart got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid_beam();
        filt_en = 1'b1; vhist = 3'b000; rd_ready = 1'b1;
        go = 1'b1;
        step();
        go = 1'b0;
        repeat (32) step();
        checks++; if (output_read_en !== 1'b1 || readin_address !== 11'd5 || slice_state !== 2'd0) begin failures++; $display("FAIL rst_at_addr5 got=%0b/%0d/%0d exp=1/5/0", output_read_en, readin_address, slice_state); end
        rst = 1'b0;
        #1;
        checks++; if (startbeamformer !== 1'b0 || output_read_en !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_async_ctl got=%0b%0b%0b exp=000", startbeamformer, output_read_en, busy); end
        checks++; if (readin_address !== 11'd0 || sample_index !== 16'd0 || slice_state !== 2'd0) begin failures++; $display("FAIL rst_async_data got=%0d/%0d/%0d exp=0/0/0", readin_address, sample_index, slice_state); end
        step();
        rst = 1'b1; filt_en = 1'b0; valid_out = 1'b0; vhist = 3'b000;
        go = 1'b1;
        step();
        go = 1'b0;
        checks++; if (signalinen !== 1'b1 || signal_address !== 11'd0) begin failures++; $display("FAIL rst_restart got=%0b/%0d exp=1/0", signalinen, signal_address); end
        step();
        checks++; if (signal_address !== 11'd1) begin failures++; $display("FAIL rst_restart_next got=%0d exp=1", signal_address); end
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_start_timing();
        test_full_frame();
        test_flush_timeout();
`ifdef SEQ_READOUT_EN
        test_readout_toggle();
`else
        test_no_readout();
`endif
        test_go_ignored();
        test_reset_mid_beam();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
